piso_serializer_bidir: RTL

//  Parallel-in/serial-out transmitter; the counterpart of our serial-in/parallel-out shifters.

---
 rtl/piso_serializer_bidir.sv | 101 ++++++++++
 1 files changed

// File: rtl/piso_serializer_bidir.sv
// rtl/piso_serializer_bidir.sv - parallel-in/serial-out transmitter, per-word shift direction.
// Optional even-parity slot after each word when PISO_PARITY_EN is defined.
module piso_serializer_bidir #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int LAST_SLOT = WIDTH;
`else
  localparam int LAST_SLOT = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_SLOT);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_next_bit;
  logic             w_next_sout;

  // r_cnt names the slot currently on sout, so the final slot is where a new word may load
  assign w_last     = (r_state == ST_SHIFT) && (r_cnt == LAST);
  assign load_ready = (r_state == ST_IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_next_bit = r_dir ? r_shift[1] : r_shift[WIDTH-2];

`ifdef PISO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^load_data;
    end
  end

  assign w_next_sout = (w_cnt_next == CNT_W'(WIDTH)) ? r_par : w_next_bit;
`else
  assign w_next_sout = w_next_bit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_dir        <= 1'b0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_accept) begin
      r_state      <= ST_SHIFT;
      r_shift      <= load_data;
      r_dir        <= load_dir;
      r_cnt        <= '0;
      r_sout       <= load_dir ? load_data[0] : load_data[WIDTH-1];
      r_sout_valid <= 1'b1;
      r_done       <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (w_last) begin
        r_state      <= ST_IDLE;
        r_sout       <= 1'b0;
        r_sout_valid <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_next;
        r_shift <= r_dir ? (r_shift >> 1) : (r_shift << 1);
        r_sout  <= w_next_sout;
        r_done  <= (w_cnt_next == LAST);
      end
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;

endmodule
